// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit (master) and the memory (slave).
interface instr_fetch_unit_if;
  logic        oMemReq;
  logic [31:0] oMemAddr;
  logic        iMemAck;
  logic [31:0] iMemData;

  modport master (output oMemReq, output oMemAddr, input iMemAck, input iMemData);
  modport slave  (input oMemReq, input oMemAddr, output iMemAck, output iMemData);
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: requests one word at PC, latches it into IR and
// tracks PC updates, deferring any PC write that arrives while a fetch is in flight.
//   state  | meaning
//   S_IDLE | no fetch in flight, PC writes applied directly
//   S_REQ  | read request outstanding, PC writes deferred, timeout counting
//   S_ERR  | misaligned PC or timeout, oFetchErr held until next iFetch
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic               iClk,
  input  logic               iRstn,
  input  logic               iFetch,
  input  logic               iWritePC,
  input  logic               iWritePCCond,
  input  logic               iZero,
  input  logic [1:0]         iOrigPC,
  input  logic [31:0]        iALUResult,
  input  logic [31:0]        iALUOut,
  instr_fetch_unit_if.master mem,
  output logic [31:0]        oInst,
  output logic               oInstValid,
  output logic [31:0]        oPC,
  output logic [31:0]        oPCOld,
  output logic               oFetchErr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_old_q, pc_old_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_q, pend_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        pc_wr;
  logic        redirect;
  logic        timeout_hit;
  logic [31:0] pc_inc;
  logic [31:0] pc_sel;
  logic [31:0] pc_redirect;

  always_comb begin
    pc_wr  = iWritePC | (iWritePCCond & iZero);
    pc_inc = pc_q + 32'd4;
    case (iOrigPC)
      2'b00:   pc_sel = iALUResult;
      2'b01:   pc_sel = iALUOut;
      2'b10:   pc_sel = pc_inc;
      default: pc_sel = pc_q;
    endcase
    // A write on the completing edge overrides an older pending one.
    redirect    = pc_wr | pend_q;
    pc_redirect = pc_wr ? pc_sel : pend_pc_q;
    timeout_hit = ({1'b0, cnt_q} + 9'd1) >= {1'b0, TIMEOUT};

    state_d   = state_q;
    pc_d      = pc_q;
    pc_old_d  = pc_old_q;
    ir_d      = ir_q;
    addr_d    = addr_q;
    pend_pc_d = pend_pc_q;
    pend_d    = pend_q;
    req_d     = req_q;
    valid_d   = valid_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_REQ: begin
        if (mem.iMemAck) begin
          state_d  = S_IDLE;
          ir_d     = mem.iMemData;
          pc_old_d = pc_q;
          valid_d  = 1'b1;
          req_d    = 1'b0;
          pc_d     = redirect ? pc_redirect : pc_inc;
          pend_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          req_d   = 1'b0;
          pend_d  = 1'b0;
          if (redirect) pc_d = pc_redirect;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (pc_wr) begin
            pend_d    = 1'b1;
            pend_pc_d = pc_sel;
          end
        end
      end
      default: begin
        if (pc_wr) pc_d = pc_sel;
        if (iFetch) begin
          valid_d = 1'b0;
          if (pc_q[1:0] == 2'b00) begin
            state_d = S_REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
            err_d   = 1'b0;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pc_old_q  <= 32'd0;
      ir_q      <= 32'd0;
      addr_q    <= RESET_PC;
      pend_pc_q <= 32'd0;
      pend_q    <= 1'b0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_old_q  <= pc_old_d;
      ir_q      <= ir_d;
      addr_q    <= addr_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mem.oMemReq  = req_q;
  assign mem.oMemAddr = addr_q;
  assign oInst        = ir_q;
  assign oInstValid   = valid_q;
  assign oPC          = pc_q;
  assign oPCOld       = pc_old_q;
  assign oFetchErr    = err_q;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 8'd255, SHALL be the maximum number of cycles the unit waits for a memory acknowledge.
REQ-003 iClk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 iRstn  in  1  SHALL be the synchronous, active-low reset.
REQ-005 iFetch  in  1  SHALL be the fetch-start pulse from control (state zero).
REQ-006 iWritePC  in  1  SHALL be the unconditional PC write enable.
REQ-007 iWritePCCond  in  1  SHALL be the branch PC write enable, qualified by iZero.
REQ-008 iZero  in  1  SHALL be the ALU zero flag.
REQ-009 iOrigPC  in  2  SHALL select the next PC: 00 iALUResult, 01 iALUOut, 10 PC+4, 11 PC (hold).
REQ-010 iALUResult / iALUOut  in  32 each  SHALL be the combinational and registered ALU results.
REQ-011 oMemReq  out  1, oMemAddr  out  32  SHALL carry the instruction-memory read request and its address.
REQ-012 iMemAck  in  1, iMemData  in  32  SHALL carry the memory acknowledge and its read data.
REQ-013 oInst  out  32, oInstValid  out  1  SHALL carry the instruction register to control and mark it as valid.
REQ-014 oPC  out  32, oPCOld  out  32  SHALL carry the current PC and the PC of the instruction held in oInst.
REQ-015 oFetchErr  out  1  SHALL be a sticky error flag, cleared by the next accepted iFetch.

Function
REQ-016 The unit SHALL use states IDLE, REQ and ERR.
REQ-017 In IDLE with iFetch=1 and PC[1:0]=00, the unit SHALL move to REQ, clear oInstValid and oFetchErr, and zero the timeout counter.
REQ-018 In IDLE with iFetch=1 and PC[1:0]!=00, the unit SHALL move to ERR, set oFetchErr, clear oInstValid, and SHALL NOT assert oMemReq.
REQ-019 In REQ, oMemReq SHALL be 1 and oMemAddr SHALL equal PC, both held stable until iMemAck or timeout.
REQ-020 On REQ with iMemAck=1, the next edge SHALL load IR<=iMemData and oPCOld<=PC, set oInstValid=1, and return to IDLE; latency is one cycle from iFetch to oMemReq and one cycle from ack to oInstValid.
REQ-021 On that same ack edge, PC SHALL become PC+4 unless a deferred write is pending, in which case the pending value SHALL be used.
REQ-022 In REQ without ack, the counter SHALL increment; when it reaches TIMEOUT the unit SHALL move to ERR, set oFetchErr, and drop oMemReq.
REQ-023 ERR SHALL be left only on iFetch, and then behaves as IDLE does for iFetch (REQ-017/018).
REQ-024 In IDLE or ERR, a PC write (iWritePC=1, or iWritePCCond=1 with iZero=1) SHALL load PC from the iOrigPC mux on the same edge.
REQ-025 In REQ, a PC write SHALL be captured into a pending register (last write wins) and applied per REQ-021; if the fetch times out, the pending value SHALL be applied on entry to ERR.
REQ-026 iFetch during REQ SHALL be ignored.
REQ-027 When iWritePC and iWritePCCond are both 1, the write SHALL occur regardless of iZero.
REQ-028 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-029 oInst and oPCOld SHALL hold their values until the next successful ack.

Reset
REQ-030 With iRstn=0 at an edge: state IDLE, PC=RESET_PC, oPCOld=0, IR=0, oInstValid=0, oMemReq=0, oMemAddr=RESET_PC, oFetchErr=0, pending write cleared, counter=0.
REQ-031 Reset asserted during REQ SHALL abort the fetch; a late iMemAck arriving after reset SHALL be ignored.

Verification
REQ-032 Reset, then iFetch; memory acks 3 cycles later with 32'h00A00093 -> oMemReq=1 with oMemAddr=0 for 3 cycles; next edge oInst=32'h00A00093, oInstValid=1, oPCOld=0, oPC=4.
REQ-033 In IDLE with PC=8, assert iWritePCCond=1, iZero=0 -> PC stays 8; repeat with iZero=1, iOrigPC=01, iALUOut=32'h40 -> PC=32'h40.
REQ-034 During REQ at PC=4, assert iWritePC with iOrigPC=00, iALUResult=32'h100; ack follows -> oPCOld=4, PC=32'h100 (not 8).
REQ-035 No ack for TIMEOUT cycles -> oFetchErr=1, oMemReq=0, state ERR; a subsequent iFetch with ack -> oFetchErr=0, oInstValid=1.
REQ-036 PC=32'h6 via iALUResult, then iFetch -> oFetchErr=1, oMemReq never asserted; PC=32'hFFFF_FFFC fetch with ack -> PC=0.
REQ-037 iRstn=0 mid-REQ with iMemAck=1 on the following cycle -> oInstValid=0, IR=0, PC=RESET_PC.
